scan_blink_mux: RTL
===================

SCAN_BLINK_MUX -- requirements
Module: scan_blink_mux

Interface
REQ-001 Parameter NUM_DIGITS, default 8: number of multiplexed digits; SHALL be >= 2.
REQ-002 Parameter DIGIT_W, default 4: code width per digit.
REQ-003 Parameter BLANK_CODE, default 4'hA: code driven on sc for a blanked digit.
REQ-004 Parameter SCAN_DIV, default 1000: clk cycles per digit slot; SHALL be >= 1.
REQ-005 Parameter BLINK_TICKS, default 100: frames per blink period.
REQ-006 Parameter BLINK_ON, default 50: visible frames per blink period; SHALL satisfy 0 < BLINK_ON <= BLINK_TICKS.
REQ-007 Ports; one clock; reset is synchronous and active-low:
  - clk  in  1  sole clock, all state on rising edge.
  - reset  in  1  synchronous, active-low.
  - digits  in  NUM_DIGITS*DIGIT_W  digit i at bits [i*DIGIT_W +: DIGIT_W]; index 0 = rightmost.
  - edit_en  in  1  enables cursor blinking and cursor moves.
  - cur_left  in  1  one-cycle pulse, cursor index +1.
  - cur_right  in  1  one-cycle pulse, cursor index -1.
  - sc  out  DIGIT_W  code for the active digit.
  - an  out  NUM_DIGITS  one-hot active-digit enable.
  - cursor  out  clog2(NUM_DIGITS)  current cursor index.
  - frame  out  1  one-cycle pulse per completed scan frame.

Function
REQ-008 Prescaler div SHALL count 0..SCAN_DIV-1 and wrap; tick is high in the cycle div == SCAN_DIV-1.
REQ-009 Scan index idx SHALL advance by 1 on each tick and wrap NUM_DIGITS-1 -> 0.
REQ-010 A frame boundary SHALL be a tick while idx == NUM_DIGITS-1; frame SHALL be high for exactly the following cycle.
REQ-011 Shadow register SHALL capture digits only at a frame boundary; the display SHALL never show a digits change mid-frame.
REQ-012 Blink counter SHALL increment at each frame boundary and wrap BLINK_TICKS-1 -> 0.
REQ-013 A digit SHALL be blanked iff edit_en=1, idx == cursor, and blink counter >= BLINK_ON.
REQ-014 sc and an SHALL be registered, with one cycle of latency from idx: an = onehot(idx); sc = BLANK_CODE if blanked, else shadow digit idx.
REQ-015 With edit_en=1: cur_left alone SHALL give cursor+1 (wrap NUM_DIGITS-1 -> 0); cur_right alone SHALL give cursor-1 (wrap 0 -> NUM_DIGITS-1); both together SHALL leave cursor unchanged.
REQ-016 Any effective cursor move SHALL clear the blink counter, so the new cursor digit shows immediately.
REQ-017 With edit_en=0, cursor SHALL hold and cur_left/cur_right SHALL be ignored.
REQ-018 A cursor move at a frame boundary SHALL take priority: the blink counter is cleared, not incremented.

Reset
REQ-019 While reset=0 at a clk edge: sc=BLANK_CODE, an=0, cursor=0, frame=0, div=0, idx=0, blink counter=0, shadow=all zeros.
REQ-020 Reset SHALL override all other activity, including mid-frame and mid-move; the first cycle after release SHALL show an = 1 (bit 0).

Structure
REQ-021 Shared package clk_disp_pkg SHALL hold the BLANK_CODE default and the clog2-width helper.
REQ-022 The prescaler SHALL be the sub-module scan_prescaler (parameter DIV, outputs tick), with the same clk/reset convention.
REQ-023 Illegal parameter values (REQ-001/004/006) SHALL cause an elaboration-time error.

Verification
All scenarios use NUM_DIGITS=8, SCAN_DIV=4, BLINK_TICKS=4, BLINK_ON=2.
REQ-024 Reset: hold reset=0 for 3 cycles -> sc=4'hA, an=0, cursor=0, frame=0; on the first cycle after release, an=8'h01.
REQ-025 Scan: digits=32'h12345678, edit_en=0 -> an steps 01,02,...,80, 4 cycles each; frame pulses every 32 cycles; frame 0 shows all 0; from frame 1, sc = 8,7,6,5,4,3,2,1.
REQ-026 Blink: edit_en=1, cursor=0 -> slot 0 shows 8 in frames 1-2 of each period and 4'hA in frames 3-4; other slots are never blanked.
REQ-027 Cursor: cur_right at 0 -> 7; cur_left at 7 -> 0; both together -> unchanged; a move during a blank phase -> next slot-0 display is the digit, not 4'hA; pulses with edit_en=0 -> no change.
REQ-028 Tearing: change digits to 32'h87654321 while idx=3 -> remaining slots of that frame keep old values; new values appear only after the next frame pulse.
REQ-029 Mid-operation reset: assert reset=0 for 1 cycle while idx=5 and blanked -> all REQ-019 values; the scan restarts at an=8'h01 and the shadow is zero until the next frame boundary.

Source files
------------

// File: rtl/clk_disp_pkg.sv
// Shared definitions for the multiplexed display blocks: default blank code
// and the index-width helper used to size counters and the cursor.
package clk_disp_pkg;

    localparam logic [3:0] BLANK_CODE_DEFAULT = 4'hA;

    // Width needed to hold an index 0..n-1; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running divider: tick is high for one cycle out of every DIV cycles,
// in the cycle where the counter sits at DIV-1.
module scan_prescaler
    import clk_disp_pkg::*;
#(
    parameter int DIV = 1000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int DW = idx_width(DIV);

    if (DIV < 1) begin : g_bad_div
        $error("scan_prescaler: DIV must be >= 1");
    end

    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;

    // Next divider value: wrap to zero on the tick cycle, otherwise count up.
    always_comb begin
        tick  = (div_q == DW'(DIV - 1));
        div_d = tick ? '0 : div_q + DW'(1);
    end

    // Divider register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/scan_blink_mux.sv
// Multiplexed digit scanner with a frame-synchronous shadow copy of the
// digit codes and an edit cursor whose digit blinks while editing is enabled.
module scan_blink_mux
    import clk_disp_pkg::*;
#(
    parameter int                 NUM_DIGITS  = 8,
    parameter int                 DIGIT_W     = 4,
    parameter logic [DIGIT_W-1:0] BLANK_CODE  = DIGIT_W'(BLANK_CODE_DEFAULT),
    parameter int                 SCAN_DIV    = 1000,
    parameter int                 BLINK_TICKS = 100,
    parameter int                 BLINK_ON    = 50
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_DIGITS*DIGIT_W-1:0]       digits,
    input  logic                                edit_en,
    input  logic                                cur_left,
    input  logic                                cur_right,
    output logic [DIGIT_W-1:0]                  sc,
    output logic [NUM_DIGITS-1:0]               an,
    output logic [idx_width(NUM_DIGITS)-1:0]    cursor,
    output logic                                frame
);

    localparam int CW = idx_width(NUM_DIGITS);
    localparam int BW = idx_width(BLINK_TICKS);

    if (NUM_DIGITS < 2) begin : g_bad_digits
        $error("scan_blink_mux: NUM_DIGITS must be >= 2");
    end
    if (SCAN_DIV < 1) begin : g_bad_div
        $error("scan_blink_mux: SCAN_DIV must be >= 1");
    end
    if ((BLINK_ON <= 0) || (BLINK_ON > BLINK_TICKS)) begin : g_bad_blink
        $error("scan_blink_mux: need 0 < BLINK_ON <= BLINK_TICKS");
    end

    logic tick;

    scan_prescaler #(
        .DIV   (SCAN_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    logic [CW-1:0]                 idx_q, idx_d;
    logic [CW-1:0]                 cursor_q, cursor_d;
    logic [BW-1:0]                 blink_q, blink_d;
    logic [NUM_DIGITS*DIGIT_W-1:0] shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0]         an_q, an_d;
    logic [DIGIT_W-1:0]            sc_q, sc_d;
    logic                          frame_q, frame_d;

    logic boundary;
    logic move_left;
    logic move_right;
    logic blanked;

    // Next-state logic: scan position, cursor, blink phase, shadow capture and
    // the registered display outputs derived from the current scan slot.
    always_comb begin
        boundary   = tick && (idx_q == CW'(NUM_DIGITS - 1));
        move_left  = edit_en && cur_left && !cur_right;
        move_right = edit_en && cur_right && !cur_left;

        idx_d = idx_q;
        if (tick) begin
            idx_d = (idx_q == CW'(NUM_DIGITS - 1)) ? '0 : idx_q + CW'(1);
        end

        cursor_d = cursor_q;
        if (move_left) begin
            cursor_d = (cursor_q == CW'(NUM_DIGITS - 1)) ? '0 : cursor_q + CW'(1);
        end else if (move_right) begin
            cursor_d = (cursor_q == '0) ? CW'(NUM_DIGITS - 1) : cursor_q - CW'(1);
        end

        // A cursor move restarts the visible phase, even on a frame boundary.
        blink_d = blink_q;
        if (move_left || move_right) begin
            blink_d = '0;
        end else if (boundary) begin
            blink_d = (32'(blink_q) == BLINK_TICKS - 1) ? '0 : blink_q + BW'(1);
        end

        shadow_d = boundary ? digits : shadow_q;
        frame_d  = boundary;

        blanked = edit_en && (idx_q == cursor_q) && (32'(blink_q) >= BLINK_ON);
        an_d    = NUM_DIGITS'(1) << idx_q;
        sc_d    = blanked ? BLANK_CODE : shadow_q[idx_q*DIGIT_W +: DIGIT_W];
    end

    // State and output registers; reset forces a blanked, disabled display.
    always_ff @(posedge clk) begin
        if (!reset) begin
            idx_q    <= '0;
            cursor_q <= '0;
            blink_q  <= '0;
            shadow_q <= '0;
            an_q     <= '0;
            sc_q     <= BLANK_CODE;
            frame_q  <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            cursor_q <= cursor_d;
            blink_q  <= blink_d;
            shadow_q <= shadow_d;
            an_q     <= an_d;
            sc_q     <= sc_d;
            frame_q  <= frame_d;
        end
    end

    assign sc     = sc_q;
    assign an     = an_q;
    assign cursor = cursor_q;
    assign frame  = frame_q;

endmodule
